// File: rtl/nibble_gen_pkg.sv
// Shared encodings for the nibble pattern generator: modes, FSM states,
// the LFSR taps and the seed fix-up that keeps LFSR/walk modes out of 0000.
`default_nettype none

package nibble_gen_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_LFSR = 2'b10;
  localparam logic [1:0] MODE_WALK = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // x^4 + x^3 + 1: feedback is d[3] ^ d[2]
  localparam logic [3:0] LFSR_TAPS  = 4'b1100;
  localparam logic [3:0] SEED_FIXUP = 4'b0001;

  function automatic logic [3:0] fix_seed(input logic [1:0] mode, input logic [3:0] seed);
    logic [3:0] r;
    r = seed;
    if (((mode == MODE_LFSR) || (mode == MODE_WALK)) && (seed == 4'b0000))
      r = SEED_FIXUP;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_pattern_step.sv
// Combinational next-word function for the four pattern modes.
`default_nettype none

module nibble_pattern_step
  import nibble_gen_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_d
);

  logic w_fb;

  assign w_fb = ^(i_d & LFSR_TAPS);

  always_comb begin
    o_d = i_d;
    case (i_mode)
      MODE_UP:   o_d = i_d + 1'b1;
      MODE_DOWN: o_d = i_d - 1'b1;
      MODE_LFSR: o_d = {i_d[WIDTH-2:0], w_fb};
      MODE_WALK: o_d = {i_d[WIDTH-2:0], i_d[WIDTH-1]};
      default:   o_d = i_d;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/nibble_pattern_gen.sv
// Burst pattern source: latches mode/seed/length on start, streams words on
// a valid/ready port, then pulses done for one cycle before returning to idle.
`default_nettype none

module nibble_pattern_gen
  import nibble_gen_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [LEN_W-1:0] i_burst_len,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_done
);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [1:0]       r_mode;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_step;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             w_xfer;
  logic             w_last;
  logic             w_valid_d;
  logic             w_busy_d;
  logic             w_done_d;

  assign w_xfer = r_valid & i_out_ready;
  assign w_last = (r_cnt == r_len);

  nibble_pattern_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_mode (r_mode),
    .i_d    (r_data),
    .o_d    (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_valid <= w_valid_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next_state = ST_RUN;
      ST_RUN:  if (w_xfer && w_last) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave straight from flops.
  always_comb begin
    w_valid_d = (w_next_state == ST_RUN);
    w_busy_d  = (w_next_state == ST_RUN);
    w_done_d  = (w_next_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_UP;
      r_len  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_mode <= i_mode;
      r_len  <= i_burst_len;
      r_cnt  <= '0;
      r_data <= fix_seed(i_mode, i_seed);
    end else if ((r_state == ST_RUN) && w_xfer && !w_last) begin
      r_data <= w_step;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_nibble_pattern_gen.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor pops on transfers.
`default_nettype none

module tb_nibble_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [1:0] i_mode = 2'b00;
  logic [3:0] i_seed = 4'h0;
  logic [3:0] i_burst_len = 4'h0;
  logic       i_out_ready = 1'b0;
  wire  [3:0] o_out_data;
  wire        o_out_valid;
  wire        o_busy;
  wire        o_done;

  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         stall_cnt = 0;
  int         idle_run = 0;
  bit         prev_xfer = 1'b0;
  bit         saw_done = 1'b0;
  bit         chk_gap = 1'b0;
  logic [3:0] exp_q[$];

  nibble_pattern_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_mode      (i_mode),
    .i_seed      (i_seed),
    .i_burst_len (i_burst_len),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when valid && ready here.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_xfer = 1'b0;
      saw_done  = 1'b0;
      idle_run  = 0;
    end else begin
      if (o_done) begin
        done_cnt++;
        check("done_after_last", prev_xfer, 1);
        saw_done = 1'b1;
        idle_run = 0;
      end
      if (o_out_valid) begin
        check("busy_with_valid", o_busy, 1);
        if (chk_gap && saw_done) begin
          check("restart_gap", idle_run, 1);
          chk_gap = 1'b0;
        end
        saw_done = 1'b0;
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          if (i_out_ready) begin
            check("data", o_out_data, exp_q[0]);
            void'(exp_q.pop_front());
          end else begin
            check("stall_hold", o_out_data, exp_q[0]);
            stall_cnt++;
          end
        end
      end else if (!o_done) begin
        idle_run++;
      end
      prev_xfer = o_out_valid && i_out_ready;
    end
  end

  task automatic start_burst(input logic [1:0] m, input logic [3:0] s, input logic [3:0] l);
    @(posedge clk); #1;
    i_mode = m; i_seed = s; i_burst_len = l; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    // Scramble the configuration inputs: the running burst must ignore them.
    i_mode = ~m; i_seed = ~s; i_burst_len = ~l;
    check("start_latency", o_out_valid, 1);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while ((done_cnt < target || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("burst_complete", (done_cnt >= target) && (exp_q.size() == 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push_list(input logic [3:0] v[$]);
    foreach (v[i]) exp_q.push_back(v[i]);
  endtask

  initial begin
    int d0;
    logic [3:0] seq[$];

    #3;
    check("rst_valid", o_out_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_data", o_out_data, 4'h0);
    #9 rst_n = 1'b1;
    i_out_ready = 1'b1;

    // Count up across the 1111 -> 0000 wrap
    seq = '{4'hE, 4'hF, 4'h0, 4'h1};
    push_list(seq);
    start_burst(2'b00, 4'hE, 4'd3);
    wait_done(1);
    check("up_last_word_kept", o_out_data, 4'h1);

    // LFSR from a zero seed: fixed up to 0001, period 15
    seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    push_list(seq);
    start_burst(2'b10, 4'h0, 4'd15);
    wait_done(2);

    // Walking rotate with three stall cycles on the second word
    seq = '{4'h1, 4'h2, 4'h4, 4'h8};
    push_list(seq);
    stall_cnt = 0;
    start_burst(2'b11, 4'h1, 4'd3);
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_out_ready = 1'b1;
    wait_done(3);
    check("stall_cycles", stall_cnt, 3);

    // Count down with start pulsed during beats 1 and 2
    seq = '{4'h1, 4'h0, 4'hF};
    push_list(seq);
    start_burst(2'b01, 4'h1, 4'd2);
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    wait_done(4);
    repeat (4) @(posedge clk);
    #1;
    check("single_done", done_cnt, 4);
    check("no_second_burst", o_out_valid, 0);

    // Asynchronous reset during beat 2
    seq = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    push_list(seq);
    start_burst(2'b00, 4'h0, 4'd7);
    @(posedge clk); #1;
    @(posedge clk); #2;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", o_out_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_data", o_out_data, 4'h0);
    exp_q.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, d0);
    check("midrst_idle", o_out_valid, 0);

    // Back-to-back bursts with start held high
    seq = '{4'h5, 4'h6, 4'h5, 4'h6};
    push_list(seq);
    chk_gap = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    i_mode = 2'b00; i_seed = 4'h5; i_burst_len = 4'd1; i_start = 1'b1;
    repeat (5) @(posedge clk);
    #1 i_start = 1'b0;
    wait_done(d0 + 2);
    check("b2b_done_count", done_cnt, d0 + 2);
    check("b2b_gap_checked", chk_gap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
